// File: rtl/mult_seq_control.sv
// Control sequencer for the shift-add sequential multiplier: CLEAR, then WIDTH ADD/SHIFT
// pairs driven by an iteration counter, then HOLD until Run is released.
module mult_seq_control #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          Signed,
  input  logic          Accumulate,
  input  logic          M,
  output logic          Shift,
  output logic          LoadA,
  output logic          fselect,
  output logic          ClearA,
  output logic          LoadB,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Count
);

  // state | meaning
  // IDLE  | waiting for Run; ClearA_LoadB command accepted here
  // CLEAR | clear A/X before a fresh (non-accumulating) multiply
  // ADD   | add (or subtract on the final signed step) S into A when M = 1
  // SHIFT | shift X:A:B right, advance the iteration counter
  // HOLD  | product ready; wait for Run to drop
  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count_nxt;
  logic          sign_q, sign_nxt;
  logic          acc_q, acc_nxt;
  logic          last;

  assign last = (Count == CW'(WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      Count  <= '0;
      sign_q <= 1'b0;
      acc_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      Count  <= count_nxt;
      sign_q <= sign_nxt;
      acc_q  <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = Count;
    sign_nxt  = sign_q;
    acc_nxt   = acc_q;
    Shift     = 1'b0;
    LoadA     = 1'b0;
    fselect   = 1'b0;
    ClearA    = 1'b0;
    LoadB     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Run) begin
          sign_nxt  = Signed;
          acc_nxt   = Accumulate;
          count_nxt = '0;
          state_nxt = Accumulate ? ADD : CLEAR;
        end else if (ClearA_LoadB) begin
          ClearA = 1'b1;
          LoadB  = 1'b1;
        end
      end
      CLEAR: begin
        // only reachable with acc_q = 0; the gate keeps A safe if that ever changes
        ClearA    = ~acc_q;
        Busy      = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        LoadA     = M;
        fselect   = sign_q & last;
        Busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        if (last) begin
          state_nxt = HOLD;
        end else begin
          count_nxt = Count + CW'(1);
          state_nxt = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
